// File: rtl/row_enc_pkg.sv
// rtl/row_enc_pkg.sv - shared sizes, FSM state type and bit/address mapping for the row encoder
package row_enc_pkg;

  localparam int ROWS   = 8;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // Row address a lives in vector bit (ROWS-1-a): address 0 is the MSB.
  function automatic logic [ADDR_W-1:0] addr_to_bit(input logic [ADDR_W-1:0] addr);
    return ADDR_W'(ROWS - 1) - addr;
  endfunction

endpackage

// File: rtl/row_pick.sv
// rtl/row_pick.sv - combinational search for the first pending row at or after a start address
//
// Ports:
//   p          pending vector, bit 7 = address 0
//   start      address the search begins at; wraps 7 -> 0
//   grant_mask one-hot vector bit of the chosen row (all zero when none)
//   addr       address of the chosen row (0 when none)
//   found      a pending row was chosen
module row_pick
  import row_enc_pkg::*;
(
  input  logic [ROWS-1:0]   p,
  input  logic [ADDR_W-1:0] start,
  output logic [ROWS-1:0]   grant_mask,
  output logic [ADDR_W-1:0] addr,
  output logic              found
);

  logic [ADDR_W-1:0] cand;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    grant_mask = '0;
    addr       = '0;
    found      = 1'b0;
    cand       = '0;
    idx        = '0;
    // Walk addresses in search order; the first hit wins because later
    // iterations are gated by found.
    for (int i = 0; i < ROWS; i++) begin
      cand = start + ADDR_W'(i);
      idx  = addr_to_bit(cand);
      if (!found && p[idx]) begin
        found           = 1'b1;
        addr            = cand;
        grant_mask[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/row_encoder.sv
// rtl/row_encoder.sv - pending-row encoder with valid/ready handshake and completion counter
//
// Ports:
//   CLOCK_50    clock, rising edge
//   resetn      asynchronous active-low reset
//   row_in      row request vector, row_in[7] = address 0
//   load        merge row_in into the pending set this cycle
//   ready       consumer accepts addr_out while valid is high
//   addr_out    registered address of the granted row
//   valid       registered, addr_out holds a granted address
//   pending     any pending row outstanding
//   done_count  completed handshakes, saturating at 15
//
// Build option: ROW_ENCODER_ROUND_ROBIN_EN selects round-robin search starting
// after the last granted address; otherwise address 0 always has priority.
module row_encoder
  import row_enc_pkg::*;
(
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [ROWS-1:0]   row_in,
  input  logic              load,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr_out,
  output logic              valid,
  output logic              pending,
  output logic [CNT_W-1:0]  done_count
);

  state_t            state;
  logic [ROWS-1:0]   p_q;
  logic [ADDR_W-1:0] start;
  logic [ROWS-1:0]   pick_mask;
  logic [ADDR_W-1:0] pick_addr;
  logic              pick_found;
  logic              take;
  logic              grant;

`ifdef ROW_ENCODER_ROUND_ROBIN_EN
  logic [ADDR_W-1:0] ptr_q;

  // Reset value 7 makes the first search start at address 0.
  assign start = ptr_q + ADDR_W'(1);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      ptr_q <= ADDR_W'(ROWS - 1);
    end else if (grant) begin
      ptr_q <= pick_addr;
    end
  end
`else
  assign start = '0;
`endif

  row_pick u_row_pick (
    .p          (p_q),
    .start      (start),
    .grant_mask (pick_mask),
    .addr       (pick_addr),
    .found      (pick_found)
  );

  // A new address may be taken when nothing is presented or the presented
  // one is being accepted this cycle.
  assign take    = (state == IDLE) || ready;
  assign grant   = take && pick_found;
  assign pending = |p_q;

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      p_q        <= '0;
      addr_out   <= '0;
      valid      <= 1'b0;
      done_count <= '0;
    end else begin
      // Clear happens before the OR so a same-cycle reload keeps the bit.
      p_q <= (p_q & ~(grant ? pick_mask : '0)) | (load ? row_in : '0);
      case (state)
        IDLE: begin
          if (pick_found) begin
            addr_out <= pick_addr;
            valid    <= 1'b1;
            state    <= PRESENT;
          end
        end
        PRESENT: begin
          if (ready) begin
            if (done_count != CNT_MAX) begin
              done_count <= done_count + CNT_W'(1);
            end
            if (pick_found) begin
              addr_out <= pick_addr;
            end else begin
              valid <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/row_encoder.md
ROW_ENCODER -- requirements
Module: row_encoder

Interface
REQ-001 SHALL have port CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port row_in  input  8  row request vector; row_in[7] corresponds to address 0, row_in[0] to address 7.
REQ-004 SHALL have port load  input  1  merge row_in into pending set this cycle.
REQ-005 SHALL have port ready  input  1  consumer accepts addr_out when valid is high.
REQ-006 SHALL have port addr_out  output  3  encoded address of granted row, registered.
REQ-007 SHALL have port valid  output  1  addr_out holds a granted address, registered.
REQ-008 SHALL have port pending  output  1  high when any pending bit is set (OR of pending register).
REQ-009 SHALL have port done_count  output  4  completed handshakes, saturating at 15.

Function
REQ-010 SHALL hold an 8-bit pending register P, with P_next = (P & ~grant_mask) | (load ? row_in : 8'h00).
REQ-011 SHALL use a two-state FSM: IDLE (valid=0) and PRESENT (valid=1).
REQ-012 In IDLE with P != 0, SHALL pick one set bit of registered P, load addr_out with its address, clear that bit in P, set valid, and go to PRESENT.
REQ-013 In IDLE with P == 0, SHALL remain in IDLE with valid=0 and addr_out unchanged.
REQ-014 In PRESENT, SHALL hold addr_out and valid stable while ready=0.
REQ-015 In PRESENT with ready=1, SHALL increment done_count (saturating at 15).
REQ-016 In PRESENT with ready=1, SHALL pick the next bit in the same cycle if P != 0 (back-to-back, valid stays 1); otherwise it SHALL clear valid and go to IDLE.
REQ-017 Bits loaded in cycle N SHALL be visible to selection from cycle N+1, so the minimum load-to-valid latency is 2 edges.
REQ-018 A bit cleared by grant and reloaded by load in the same cycle SHALL remain set.
REQ-019 Loading an already-pending bit SHALL NOT create a duplicate grant.
REQ-020 Default selection is fixed priority: row_in[7] (address 0) highest, row_in[0] (address 7) lowest.
REQ-021 The encoding SHALL be addr = 7 - bit_index, the exact inverse of the team's 3-to-8 row decoder.
REQ-022 ready while valid=0 SHALL have no effect.

Reset
REQ-023 On resetn=0, SHALL asynchronously set P=8'h00, FSM=IDLE, addr_out=3'd0, valid=0, done_count=4'd0, and the round-robin pointer to 3'd7.
REQ-024 A reset asserted during PRESENT SHALL discard the in-flight grant and all pending bits.
REQ-025 The first selection after reset deassertion SHALL occur no earlier than the first edge with resetn=1.

Configuration
REQ-026 The macro ROW_ENCODER_ROUND_ROBIN_EN, when defined, SHALL make selection round-robin: the search starts at address (last granted address + 1) mod 8 and wraps 7 -> 0.
REQ-027 When ROW_ENCODER_ROUND_ROBIN_EN is defined, the pointer SHALL update only on a grant.
REQ-028 Without ROW_ENCODER_ROUND_ROBIN_EN, SHALL use the fixed priority of REQ-020, and the pointer register SHALL be absent.
REQ-029 In both configurations, the port list SHALL be identical.

Structure
REQ-030 The shared package row_enc_pkg SHALL hold ROWS=8, ADDR_W=3, CNT_W=4, and the FSM state typedef (IDLE, PRESENT).
REQ-031 One combinational sub-module, row_pick, SHALL take P and the start address and return grant_mask, the address, and a found flag; row_encoder instantiates it once.

Verification
REQ-032 Single request: load=1 with row_in=8'b0000_0100, ready=1 -> valid high 2 edges later with addr_out=5, then valid=0 and done_count=1.
REQ-033 Fixed priority: load row_in=8'b1000_0001 once, ready=1 -> addr_out sequence 0 then 7 on consecutive cycles; valid stays high for 2 cycles.
REQ-034 Backpressure: pending 8'b0011_0000 with ready=0 for 5 cycles -> addr_out=2 held steady with valid=1; after ready=1 -> addr_out 2 then 3.
REQ-035 Round robin (ROW_ENCODER_ROUND_ROBIN_EN defined): all 8 bits pending and reloaded every cycle, ready=1 -> addr_out runs 0,1,...,7,0; without the macro -> 0 repeatedly.
REQ-036 Same-cycle reload and saturation: reload the bit being granted -> it is granted again; 20 handshakes -> done_count=15.
REQ-037 Reset mid-PRESENT: resetn=0 while valid=1 and P=8'hF0 -> valid=0, pending=0, done_count=0 immediately without waiting for a clock edge.
